// File: rtl/norm2_mul_arbiter.sv
// Round-robin arbiter sharing one A_W x B_W unsigned multiplier between two requesters.
// Each requester owns a one-entry result register, so a stalled consumer only blocks its own path.
module norm2_mul_arbiter #(
  parameter int A_W = 25,
  parameter int B_W = 6,
  parameter int P_W = 31
) (
  input  logic           ap_clk,
  input  logic           ap_rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [A_W-1:0] req0_a,
  input  logic [B_W-1:0] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [A_W-1:0] req1_a,
  input  logic [B_W-1:0] req1_b,
  output logic           res0_valid,
  input  logic           res0_ready,
  output logic [P_W-1:0] res0_p,
  output logic           res1_valid,
  input  logic           res1_ready,
  output logic [P_W-1:0] res1_p,
  output logic           idle
);

  // prio = 0 favours requester 0 on a tie, prio = 1 favours requester 1.
  logic           prio;
  logic           elig0, elig1;
  logic           grant0, grant1;
  logic [A_W-1:0] op_a;
  logic [B_W-1:0] op_b;
  logic [P_W-1:0] prod;

  function automatic logic [P_W-1:0] mul_exact(input logic [A_W-1:0] a,
                                                input logic [B_W-1:0] b);
    return P_W'(a) * P_W'(b);
  endfunction

  always_comb begin
    elig0  = req0_valid & (~res0_valid | res0_ready);
    elig1  = req1_valid & (~res1_valid | res1_ready);
    grant0 = ~ap_rst & elig0 & (~elig1 | ~prio);
    grant1 = ~ap_rst & elig1 & (~elig0 |  prio);
    op_a   = grant1 ? req1_a : req0_a;
    op_b   = grant1 ? req1_b : req0_b;
    prod   = mul_exact(op_a, op_b);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign idle       = ~req0_valid & ~req1_valid & ~res0_valid & ~res1_valid;

  // Result stage: a load always wins over a same-cycle drain.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      prio       <= 1'b0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      res0_p     <= '0;
      res1_p     <= '0;
    end else begin
      if (grant0 | grant1)
        prio <= grant0;
      if (grant0) begin
        res0_p     <= prod;
        res0_valid <= 1'b1;
      end else if (res0_ready) begin
        res0_valid <= 1'b0;
      end
      if (grant1) begin
        res1_p     <= prod;
        res1_valid <= 1'b1;
      end else if (res1_ready) begin
        res1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/norm2_mul_arbiter.md
# norm2_mul_arbiter

Round-robin arbiter that shares the single 25x6 unsigned multiplier in the norm2 (local response normalization) kernel between two requesters. Requester 0 is the squared-sum scaling path and requester 1 is the output-scaling path. The arbiter accepts at most one operand pair per cycle and computes the exact 31-bit product. It returns the product to the owning requester through a private one-entry result register, so a stalled consumer never blocks the other requester.

## Interface
Parameters:
- A_W, 25, width of operand a (unsigned)
- B_W, 6, width of operand b (unsigned)
- P_W, 31, product width; must equal A_W+B_W

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 pair accepted this cycle
- req0_a  in  A_W  operand a, requester 0
- req0_b  in  B_W  operand b, requester 0
- req1_valid / req1_ready / req1_a / req1_b  same as above, requester 1
- res0_valid  out  1  result register 0 holds a product
- res0_ready  in  1  consumer 0 takes the result this cycle
- res0_p  out  P_W  product for requester 0
- res1_valid / res1_ready / res1_p  same as above, requester 1
- idle  out  1  no request pending and both result registers empty

## Operation
- Handshake: a transfer occurs when valid and ready are both high in the same cycle. A requester must hold valid and its operands stable until ready. The ready outputs may depend combinationally on valid; valid must never depend on ready.
- Eligibility: elig_k = reqk_valid & (!resk_valid | resk_ready). A result register is treated as free when it is empty or is being drained in the same cycle.
- Grant:
  - Only one of elig0/elig1 is high: that requester is granted.
  - Both are high: the requester named by priority pointer prio wins.
  - Neither is high: no grant.
  - reqk_ready = grant_k. At most one ready is high per cycle.
- Pointer: after any grant, prio moves to the requester that did not win. With no grant, prio holds.
- Datapath:
  - One multiplier instance takes its operands through a mux selected by the grant.
  - p = zero-extended a × zero-extended b, exact with no truncation. The maximum result 0x1FFFFFF × 0x3F = 0x7DFFFFC1 fits in P_W bits.
- Result register k, evaluated each cycle:
  - grant_k: load resk_p and set resk_valid=1. This applies even if the register is draining in the same cycle (load wins).
  - No grant_k and resk_ready & resk_valid: clear resk_valid.
  - Otherwise: hold.
- resk_p is frozen while resk_valid=1 and resk_ready=0.
- idle = !req0_valid & !req1_valid & !res0_valid & !res1_valid. It is combinational.
- There is no FSM beyond the prio bit and two valid bits. The state is prio, res0_valid, res0_p, res1_valid and res1_p.

## Timing
- Latency is 1 cycle: a pair accepted at edge n appears on resk_p/resk_valid after edge n, and can be consumed in cycle n+1.
- Throughput:
  - One product per cycle total.
  - With both requesters continuously valid and both consumers always ready, grants alternate 0,1,0,1 with no gaps.
  - A single requester with its consumer always ready is granted every cycle.
- Back-pressure: while resk_valid=1 and resk_ready=0, reqk_ready stays 0. The other requester may be granted every cycle meanwhile.
- Reset (ap_rst=1 at an edge):
  - res0_valid=0, res1_valid=0, res0_p=0, res1_p=0, prio=0 (requester 0 favoured).
  - While ap_rst is high, req0_ready=req1_ready=0 and no grant occurs.
  - Reset mid-operation discards any held product without delivering it.
- First cycle after reset, with both requesters valid: requester 0 is granted.

## Test plan
- Single op: after reset, req0 a=1000, b=7, res0_ready=1. Expect req0_ready=1 in cycle 0; res0_valid=1 and res0_p=7000 in cycle 1; idle=1 in cycle 2.
- Max operands: req1 a=0x1FFFFFF, b=0x3F. Expect res1_p=0x7DFFFFC1 one cycle later. Also a=0x1FFFFFF, b=0 → res1_p=0.
- Round-robin: both requesters valid continuously with distinct operands, both consumers ready. Expect grants 0,1,0,1… from reset, one per cycle, each product routed to the correct port.
- Back-pressure isolation: hold res0_ready=0 while res0_valid=1 for 5 cycles with both requesters valid. Expect req0_ready=0 and res0_p frozen for 5 cycles, and req1 granted in each of those 5 cycles. Release res0_ready: req0 is granted in that same cycle (drain and load together), and the new product appears the next cycle.
- Reset mid-stream: assert ap_rst for 1 cycle while res0_valid=1 and res1_valid=1. Expect both valids 0 and both products 0 after the edge, no ready during reset, and prio favouring requester 0 afterwards.
- Random soak: 10k cycles of random valids, readies and operands checked against a reference model. Checks: products exact and in order per requester; never both readies high in one cycle; no lost or duplicated results.
